// File: rtl/counter_mod_n.sv
// ---------------------------------------------------------------------------
// counter_mod_n
//
// Parametrised modulo-MOD up/down counter for digit and stage chains in
// timer and display paths. Stages cascade: the next stage's en is driven by
// this stage's c. With ONE_SHOT=1 the counter stops on its terminal value and
// raises done instead of wrapping.
//
// Parameters
//   counting modulus MOD, 2..2**WIDTH; q cycles through 0..MOD-1
//   WIDTH    width of q and load_val
//   ONE_SHOT 0 = wrap-around counting, 1 = stop at terminal and raise done
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous active-low reset (0 = reset)
//   en       count enable, also the cascade carry-in
//   d        direction: 0 = up, 1 = down
//   clr      synchronous clear to 0 (highest priority)
//   load     synchronous parallel load (saturates at MOD-1)
//   load_val value to load
//   q        current count (registered)
//   c        terminal-count carry/borrow (combinational)
//   done     one-shot completion flag (registered; tied low when ONE_SHOT=0)
// ---------------------------------------------------------------------------
module counter_mod_n #(
  parameter int unsigned MOD      = 10,
  parameter int unsigned WIDTH    = 4,
  parameter bit          ONE_SHOT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             d,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             c,
  output logic             done
);

  // All arithmetic is carried one bit wider than q so that MOD == 2**WIDTH
  // and out-of-range load values compare correctly.
  localparam logic [WIDTH:0]   MAX_V  = (WIDTH+1)'(MOD - 32'd1);
  localparam logic [WIDTH:0]   ONE_V  = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   ZERO_X = {(WIDTH+1){1'b0}};
  localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};

  logic [WIDTH-1:0] q_r;
  logic             done_r;
  logic [WIDTH-1:0] q_nxt_s;
  logic             done_nxt_s;
  logic [WIDTH:0]   q_ext_s;
  logic [WIDTH:0]   term_s;
  logic [WIDTH:0]   step_s;
  logic             at_term_s;
  logic             count_s;

  // Limit a wide value to the legal range 0..MOD-1. Used both for load
  // saturation and as a guard on every arithmetic next-state value.
  function automatic logic [WIDTH-1:0] clamp_to_mod(input logic [WIDTH:0] v);
    if (v > MAX_V) begin
      return MAX_V[WIDTH-1:0];
    end else begin
      return v[WIDTH-1:0];
    end
  endfunction

  assign q_ext_s   = {1'b0, q_r};
  // Terminal value depends on the current direction, so a direction change
  // is seen on the very next counting edge.
  assign term_s    = d ? ZERO_X : MAX_V;
  assign at_term_s = (q_ext_s == term_s);
  // A counting edge: enabled, not overridden by clr/load, not parked in done.
  assign count_s   = en & ~clr & ~load & ~done_r;
  assign step_s    = d ? (q_ext_s - ONE_V) : (q_ext_s + ONE_V);

  // Carry/borrow is forced low during reset so a downstream stage cannot count.
  assign c    = rst & count_s & at_term_s;
  assign q    = q_r;
  assign done = done_r;

  // Next-state selection: clr > load > count > hold.
  always_comb begin
    q_nxt_s    = q_r;
    done_nxt_s = done_r;
    if (clr) begin
      q_nxt_s    = ZERO_V;
      done_nxt_s = 1'b0;
    end else if (load) begin
      q_nxt_s    = clamp_to_mod({1'b0, load_val});
      done_nxt_s = 1'b0;
    end else if (count_s) begin
      if (at_term_s) begin
        if (ONE_SHOT) begin
          // Park on the terminal value; only clr, load or reset release it.
          q_nxt_s    = q_r;
          done_nxt_s = 1'b1;
        end else begin
          q_nxt_s    = d ? MAX_V[WIDTH-1:0] : ZERO_V;
          done_nxt_s = 1'b0;
        end
      end else begin
        q_nxt_s    = clamp_to_mod(step_s);
        done_nxt_s = done_r;
      end
    end else begin
      q_nxt_s    = q_r;
      done_nxt_s = done_r;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r    <= ZERO_V;
      done_r <= 1'b0;
    end else begin
      q_r    <= q_nxt_s;
      done_r <= done_nxt_s;
    end
  end

endmodule

// File: tb/tb_counter_mod_n.sv
module tb_counter_mod_n;

  localparam int unsigned M0 = 10;
  localparam int unsigned W0 = 4;
  localparam int unsigned M1 = 6;
  localparam int unsigned W1 = 3;

  if ((M0 > 2**W0) || (M1 > 2**W1)) begin : g_param_bad
    initial $fatal(1, "FAIL param: MOD exceeds 2**WIDTH");
  end

  logic clk;
  logic rst;

  // u0: default wrap-around counter
  logic          en0, d0, clr0, load0;
  logic [W0-1:0] lv0, q0;
  logic          c0, done0;
  // u1: MOD=6 one-shot counter
  logic          en1, d1, clr1, load1;
  logic [W1-1:0] lv1, q1;
  logic          c1, done1;
  // cascade pair
  logic          cen;
  logic [W0-1:0] cq0, cq1;
  logic          cc0, cc1, cdone0, cdone1;

  counter_mod_n #(.MOD(M0), .WIDTH(W0), .ONE_SHOT(1'b0)) u0 (
    .clk(clk), .rst(rst), .en(en0), .d(d0), .clr(clr0), .load(load0),
    .load_val(lv0), .q(q0), .c(c0), .done(done0));

  counter_mod_n #(.MOD(M1), .WIDTH(W1), .ONE_SHOT(1'b1)) u1 (
    .clk(clk), .rst(rst), .en(en1), .d(d1), .clr(clr1), .load(load1),
    .load_val(lv1), .q(q1), .c(c1), .done(done1));

  counter_mod_n #(.MOD(M0), .WIDTH(W0), .ONE_SHOT(1'b0)) s0 (
    .clk(clk), .rst(rst), .en(cen), .d(1'b0), .clr(1'b0), .load(1'b0),
    .load_val(4'd0), .q(cq0), .c(cc0), .done(cdone0));

  counter_mod_n #(.MOD(M0), .WIDTH(W0), .ONE_SHOT(1'b0)) s1 (
    .clk(clk), .rst(rst), .en(cc0), .d(1'b0), .clr(1'b0), .load(1'b0),
    .load_val(4'd0), .q(cq1), .c(cc1), .done(cdone1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sel;
    logic       clr;
    logic       load;
    logic [3:0] lv;
    logic       en;
    logic       d;
    logic [3:0] eq;
    logic       ec;
    logic       edone;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic       done;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic sel, input logic clr, input logic load,
                     input logic [3:0] lv, input logic en, input logic d,
                     input logic [3:0] eq, input logic ec, input logic edone);
    vec_t v;
    v.sel = sel; v.clr = clr; v.load = load; v.lv = lv; v.en = en; v.d = d;
    v.eq = eq; v.ec = ec; v.edone = edone;
    tbl.push_back(v);
  endtask

  initial begin
    vec_t v;
    exp_t e;

    // ---------------- vector table ----------------
    // u0 up run from 0: 12 edges, c while q==9
    for (int i = 0; i < 12; i++)
      add(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'((i + 1) % 10), (i % 10) == 9, 1'b0);
    add(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);       // clr at q=2
    // u0 down run from 0: q 9,8,..,0,9,8 ; c while q==0
    for (int i = 0; i < 12; i++)
      add(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'((19 - i) % 10), ((20 - i) % 10) == 0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0);       // load 3
    add(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd4, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd4, 1'b0, 1'b0);       // flip to down at 5
    add(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd4, 1'b0, 1'b0);       // flip back up
    add(1'b0, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 4'd7, 1'b0, 1'b0);       // load 7
    add(1'b0, 1'b0, 1'b1, 4'd13, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0);      // saturate
    add(1'b0, 1'b0, 1'b1, 4'd15, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 4'd10, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0);      // modulus boundary
    add(1'b0, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);       // clr beats load, c masked
    add(1'b0, 1'b0, 1'b1, 4'd9, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0);       // en=0 holds, c=0 at 9
    add(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);       // wrap 9->0
    add(1'b0, 1'b0, 1'b1, 4'd9, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 4'd4, 1'b1, 1'b0, 4'd4, 1'b0, 1'b0);       // load masks c at 9
    add(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd9, 1'b1, 1'b0);       // borrow 0->9
    add(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);       // up terminal at 9
    // u1 one-shot MOD=6
    add(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      add(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'(i + 1), 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b1);       // stop at 5, done
    add(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 1'b0, 1'b1);       // en ignored
    add(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd5, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd5, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0);       // load clears done
    add(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1);       // down stop at 0
    add(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
    add(1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);       // clr clears done
    add(1'b1, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0);       // saturate to 5
    add(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b1);

    // ---------------- reset ----------------
    rst = 1'b0; cen = 1'b0;
    en0 = 1'b1; d0 = 1'b0; clr0 = 1'b0; load0 = 1'b0; lv0 = 4'd0;
    en1 = 1'b1; d1 = 1'b0; clr1 = 1'b0; load1 = 1'b0; lv1 = 3'd0;
    #3;
    chk("reset q0", q0, 8'd0);
    chk("reset c0", c0, 8'd0);
    chk("reset done1", done1, 8'd0);
    @(posedge clk); #1;
    chk("reset hold q0", q0, 8'd0);
    chk("reset hold q1", q1, 8'd0);
    rst = 1'b1;

    // ---------------- table with scoreboard ----------------
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      if (v.sel == 1'b0) begin
        clr0 = v.clr; load0 = v.load; lv0 = v.lv; en0 = v.en; d0 = v.d;
        clr1 = 1'b0; load1 = 1'b0; en1 = 1'b0;
      end else begin
        clr1 = v.clr; load1 = v.load; lv1 = v.lv[2:0]; en1 = v.en; d1 = v.d;
        clr0 = 1'b0; load0 = 1'b0; en0 = 1'b0;
      end
      #2;
      chk($sformatf("vec%0d c", i), (v.sel ? c1 : c0), {7'd0, v.ec});
      e.q = {4'd0, v.eq}; e.done = v.edone;
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      chk($sformatf("vec%0d q", i), (v.sel ? {5'd0, q1} : {4'd0, q0}), e.q);
      chk($sformatf("vec%0d done", i), (v.sel ? done1 : done0), {7'd0, e.done});
    end
    clr0 = 1'b0; load0 = 1'b0; en0 = 1'b0;
    clr1 = 1'b0; load1 = 1'b0; en1 = 1'b0;

    // ---------------- cascade 00..99 -> 00 ----------------
    cen = 1'b1;
    for (int k = 1; k <= 101; k++) begin
      e.q = 8'(((k % 100) / 10) * 16 + (k % 10)); e.done = 1'b0;
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      chk($sformatf("cascade k=%0d", k), {cq1, cq0}, e.q);
    end
    cen = 1'b0;

    // ---------------- async reset mid-count ----------------
    load0 = 1'b1; lv0 = 4'd6;
    @(posedge clk); #1;
    load0 = 1'b0; en0 = 1'b1; d0 = 1'b0;
    chk("pre-reset q0", q0, 8'd6);
    #2 rst = 1'b0;
    #1;
    chk("async q0", q0, 8'd0);
    chk("async c0", c0, 8'd0);
    chk("async done1", done1, 8'd0);
    @(posedge clk); #1;
    chk("async hold q0", q0, 8'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("restart q0", q0, 8'd1);
    @(posedge clk); #1;
    chk("restart q0 b", q0, 8'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_mod_n.md
Name: counter_mod_n

Overview:
- Parametrised modulo-N up/down counter; successor to the fixed mod-10 counter.
- Adds: configurable modulus/width, count enable, synchronous clear, parallel load, cascadable terminal-count output, and an optional one-shot (stop-at-terminal) mode.
- Used as a digit/stage counter in timer and display chains. Instances cascade by driving the next stage's `en` from this stage's `c`.

Parameters:
- MOD, 10, counting modulus; legal range 2..2^WIDTH; q cycles 0..MOD-1.
- WIDTH, 4, width of q and load_val; the bench asserts MOD <= 2**WIDTH at elaboration.
- ONE_SHOT, 0, 0 = wrap-around counting; 1 = stop at terminal value and raise done.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- en  input  1  count enable; also the cascade carry-in.
- d  input  1  direction: 0 = up, 1 = down.
- clr  input  1  synchronous clear to 0.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value to load.
- q  output  WIDTH  current count.
- c  output  1  terminal-count carry/borrow; combinational.
- done  output  1  one-shot completion flag; registered.

Behaviour:
- Reset (rst=0, asynchronous): q=0 and done=0 immediately; c forced 0 while rst=0. On rst release, operation resumes at the next rising edge.
- Per-edge priority, highest first: clr > load > count.
- clr=1: q<=0, done<=0.
- load=1 (clr=0): q<=load_val if load_val<=MOD-1, else q<=MOD-1 (saturating). done<=0.
- Count (clr=0, load=0, en=1, done=0):
  - d=0: q<=q+1; at q=MOD-1, q<=0.
  - d=1: q<=q-1; at q=0, q<=MOD-1.
  - If en=0, q holds.
- Terminal value is MOD-1 when d=0, and 0 when d=1.
- c = rst & en & ~clr & ~load & ~done & (q==terminal). Same-cycle combinational; its width is one cycle per wrap at en=1.
- ONE_SHOT=0: done is tied 0; the counter wraps indefinitely.
- ONE_SHOT=1:
  - On a count edge where the current q==terminal, q holds (no wrap) and done<=1; c is asserted in that cycle.
  - While done=1, en is ignored, q holds, and c=0.
  - done clears only on clr, load or reset.
- A direction change takes effect on the next counting edge; there is no extra latency.
- Latency: q updates 1 cycle after the qualifying edge; c has zero latency relative to q/en/d.
- Arithmetic is done in WIDTH+1 bits internally; q never leaves 0..MOD-1, including for non-power-of-two MOD.
- Reset asserted mid-count: q=0 in the same cycle, without waiting for a clock edge. No state survives reset.
- clr and load asserted together: clr wins and load_val is ignored.

Test Plan:
- Defaults, rst=0 then release, en=1, d=0, 12 clocks → q: 0,1,…,9,0,1; c=1 exactly while q=9; done=0 throughout.
- Defaults, d=1 from q=0, 12 clocks → q: 9,8,…,0,9,8; c=1 while q=0 and en=1; flip d mid-run at q=5 → next q=4.
- load=1, load_val=7 → q=7 next edge; load_val=13 → q=9 (saturate). clr+load same cycle → q=0. en toggled 0 → q holds and c=0 even at q=9.
- MOD=6, WIDTH=3, ONE_SHOT=1, d=0, en=1 from q=0 → q reaches 5; next edge q stays 5, done=1, c pulses one cycle; further en ignored; load_val=2 → q=2, done=0.
- Two cascaded MOD=10 instances (stage1.en = stage0.c), 100 clocks → stage1 increments on each stage0 9→0 wrap; combined value 00..99 then 00.
- Assert rst=0 asynchronously between edges at q=6 → q=0, c=0, done=0 before the next edge; release → counting restarts from 0.
